// File: rtl/dct_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | dct_pkg : shared constants, bank-state encoding and address packing for   |
// |           the 2D DCT transpose path.                                       |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
package dct_pkg;

    localparam int DCT_N      = 8;
    localparam int DCT_LOG2N  = 3;
    localparam int DCT_ADDR_W = 2 * DCT_LOG2N;
    localparam int DCT_WORDS  = DCT_N * DCT_N;

    localparam logic [DCT_LOG2N-1:0] DCT_IDX_LAST = DCT_LOG2N'(DCT_N - 1);

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

    function automatic logic [DCT_ADDR_W-1:0] pack_addr(
        input logic [DCT_LOG2N-1:0] row,
        input logic [DCT_LOG2N-1:0] col
    );
        return {row, col};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dct_tpose_bank.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | dct_tpose_bank : 64-word single-write store with a registered, enabled    |
// |                  read port whose output holds while rd_en is low.         |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module dct_tpose_bank
    import dct_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DCT_ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    input  logic [DCT_ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0]     rd_data
);

    logic [DATA_W-1:0] mem_q [DCT_WORDS];
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/dct_transpose_buf.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | dct_transpose_buf : ping-pong 8x8 transpose buffer between row and column |
// |                     DCT passes. Optional DCT_TPOSE_CHECK_EN adds the      |
// |                     input-ordering checker driving proto_err.            |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module dct_transpose_buf
    import dct_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    in_coef,
    input  logic [DCT_LOG2N-1:0] in_index,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_coef,
    output logic [DCT_LOG2N-1:0] out_index,
    output logic                 out_last,
    output logic                 out_block_last,
    output logic                 overflow,
    output logic                 proto_err
);

    bank_state_e          state_q [2];
    bank_state_e          state_d [2];
    logic                 wr_bank_q, wr_bank_d;
    logic [DCT_LOG2N-1:0] wr_row_q, wr_row_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [DCT_LOG2N-1:0] rd_row_q, rd_row_d;
    logic [DCT_LOG2N-1:0] rd_col_q, rd_col_d;
    logic                 out_valid_q, out_valid_d;
    logic [DCT_LOG2N-1:0] out_index_q, out_index_d;
    logic                 out_last_q, out_last_d;
    logic                 out_block_last_q, out_block_last_d;
    logic                 out_bank_q, out_bank_d;
    logic                 overflow_q, overflow_d;

    logic [1:0]           bank_we;
    logic [1:0]           bank_re;
    logic [DATA_W-1:0]    bank_rdata [2];
    logic                 blk_release;
    logic                 wr_ok;
    logic                 accept;
    logic                 load;
    logic                 issue;

    always_comb begin
        state_d          = state_q;
        wr_bank_d        = wr_bank_q;
        wr_row_d         = wr_row_q;
        rd_bank_d        = rd_bank_q;
        rd_row_d         = rd_row_q;
        rd_col_d         = rd_col_q;
        out_valid_d      = out_valid_q;
        out_index_d      = out_index_q;
        out_last_d       = out_last_q;
        out_block_last_d = out_block_last_q;
        out_bank_d       = out_bank_q;
        overflow_d       = overflow_q;
        bank_we          = '0;
        bank_re          = '0;

        // Read side: the final handshake frees the bank that fed it; the
        // issue pointer has already moved to the other bank by then.
        blk_release = out_valid_q && out_ready && out_block_last_q;
        if (blk_release) begin
            state_d[out_bank_q] = BANK_EMPTY;
        end

        load  = !out_valid_q || out_ready;
        issue = load && (state_q[rd_bank_q] == BANK_FULL ||
                         state_q[rd_bank_q] == BANK_DRAINING);
        if (issue) begin
            bank_re[rd_bank_q] = 1'b1;
            state_d[rd_bank_q] = BANK_DRAINING;
            out_index_d        = rd_row_q;
            out_last_d         = (rd_row_q == DCT_IDX_LAST);
            out_block_last_d   = (rd_row_q == DCT_IDX_LAST) && (rd_col_q == DCT_IDX_LAST);
            out_bank_d         = rd_bank_q;
            rd_row_d           = rd_row_q + 1'b1;
            if (rd_row_q == DCT_IDX_LAST) begin
                rd_col_d = rd_col_q + 1'b1;
                if (rd_col_q == DCT_IDX_LAST) begin
                    rd_bank_d = ~rd_bank_q;
                end
            end
        end
        if (load) begin
            out_valid_d = issue;
        end

        // Write side. A bank released on this edge has already had its last
        // word read out, so the next block's first sample may land in it;
        // this keeps the input at full rate across block boundaries.
        wr_ok  = (state_q[wr_bank_q] == BANK_EMPTY) ||
                 (state_q[wr_bank_q] == BANK_FILLING) ||
                 (blk_release && (out_bank_q == wr_bank_q));
        accept = in_valid && wr_ok;
        if (in_valid && !wr_ok) begin
            overflow_d = 1'b1;
        end
        if (accept) begin
            bank_we[wr_bank_q] = 1'b1;
            state_d[wr_bank_q] = BANK_FILLING;
            if (in_last) begin
                if (wr_row_q == DCT_IDX_LAST) begin
                    state_d[wr_bank_q] = BANK_FULL;
                    wr_row_d           = '0;
                    wr_bank_d          = ~wr_bank_q;
                end else begin
                    wr_row_d = wr_row_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= BANK_EMPTY;
            end
            wr_bank_q        <= 1'b0;
            wr_row_q         <= '0;
            rd_bank_q        <= 1'b0;
            rd_row_q         <= '0;
            rd_col_q         <= '0;
            out_valid_q      <= 1'b0;
            out_index_q      <= '0;
            out_last_q       <= 1'b0;
            out_block_last_q <= 1'b0;
            out_bank_q       <= 1'b0;
            overflow_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            wr_bank_q        <= wr_bank_d;
            wr_row_q         <= wr_row_d;
            rd_bank_q        <= rd_bank_d;
            rd_row_q         <= rd_row_d;
            rd_col_q         <= rd_col_d;
            out_valid_q      <= out_valid_d;
            out_index_q      <= out_index_d;
            out_last_q       <= out_last_d;
            out_block_last_q <= out_block_last_d;
            out_bank_q       <= out_bank_d;
            overflow_q       <= overflow_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            dct_tpose_bank #(
                .DATA_W (DATA_W)
            ) u_bank (
                .clk     (clk),
                .reset   (reset),
                .wr_en   (bank_we[gi]),
                .wr_addr (pack_addr(wr_row_q, in_index)),
                .wr_data (in_coef),
                .rd_en   (bank_re[gi]),
                .rd_addr (pack_addr(rd_row_q, rd_col_q)),
                .rd_data (bank_rdata[gi])
            );
        end
    endgenerate

    assign out_valid      = out_valid_q;
    assign out_coef       = bank_rdata[out_bank_q];
    assign out_index      = out_index_q;
    assign out_last       = out_last_q;
    assign out_block_last = out_block_last_q;
    assign overflow       = overflow_q;

`ifdef DCT_TPOSE_CHECK_EN
    logic [DCT_LOG2N-1:0] exp_col_q, exp_col_d;
    logic                 proto_err_q, proto_err_d;

    always_comb begin
        exp_col_d   = exp_col_q;
        proto_err_d = proto_err_q;
        if (accept) begin
            if ((in_index != exp_col_q) || (in_last && (in_index != DCT_IDX_LAST))) begin
                proto_err_d = 1'b1;
            end
            exp_col_d = in_last ? '0 : exp_col_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_col_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            exp_col_q   <= exp_col_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign proto_err = proto_err_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dct_transpose_buf.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_dct_transpose_buf : directed self-checking bench for dct_transpose_buf |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module tb_dct_transpose_buf;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_coef = '0;
    logic [2:0]  in_index = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_coef;
    logic [2:0]  out_index;
    logic        out_last;
    logic        out_block_last;
    logic        overflow;
    logic        proto_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] q_coef [$];
    logic [2:0]  q_idx  [$];
    bit          q_last [$];
    bit          q_blast[$];
    int          stall_chg;
    int          gaps;

    dct_transpose_buf #(.DATA_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_coef        (in_coef),
        .in_index       (in_index),
        .in_last        (in_last),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_coef       (out_coef),
        .out_index      (out_index),
        .out_last       (out_last),
        .out_block_last (out_block_last),
        .overflow       (overflow),
        .proto_err      (proto_err)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Block b row r col c carries (base+b)*256 + 16*r + c.
    task automatic write_blocks(input int nb, input int base);
        for (int b = 0; b < nb; b++)
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) begin
                    @(negedge clk);
                    in_valid = 1'b1;
                    in_coef  = 16'((base + b) * 256 + 16 * r + c);
                    in_index = 3'(c);
                    in_last  = (c == 7);
                end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // mode 0: ready always high; mode 1: ready high one cycle in three.
    task automatic collect(input int n, input int mode, input int budget);
        int cyc;
        bit rdy, held_v, started;
        logic [21:0] held, cur;
        q_coef.delete(); q_idx.delete(); q_last.delete(); q_blast.delete();
        stall_chg = 0; gaps = 0; cyc = 0; held_v = 0; started = 0; held = '0;
        while (q_coef.size() < n && cyc < budget) begin
            @(negedge clk);
            cur = {out_valid, out_coef, out_index, out_last, out_block_last};
            if (held_v && cur !== held) stall_chg++;
            if (started && !out_valid) gaps++;
            rdy = (mode == 0) || (cyc % 3 == 2);
            out_ready = rdy;
            held_v = out_valid && !rdy;
            held   = cur;
            if (out_valid && rdy) begin
                q_coef.push_back(out_coef);
                q_idx.push_back(out_index);
                q_last.push_back(out_last);
                q_blast.push_back(out_block_last);
                started = 1;
            end
            cyc++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({out_valid, out_coef, out_index, out_last, out_block_last} !== 22'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%0b coef=%0d idx=%0d last=%0b blast=%0b, want all 0",
                     out_valid, out_coef, out_index, out_last, out_block_last);
        end
        n_cmp++;
        if (overflow !== 1'b0 || proto_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: got overflow=%0b proto_err=%0b, want 0 0", overflow, proto_err);
        end
    endtask

    task automatic test_single_block();
        int e, row, col, expv;
        do_reset();
        write_blocks(1, 0);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_latency_e0: out_valid=%0b, want 0 one edge after last input", out_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || out_coef !== 16'd0 || out_index !== 3'd0) begin
            n_err++;
            $display("FAIL single_latency_e1: v=%0b coef=%0d idx=%0d, want 1 0 0", out_valid, out_coef, out_index);
        end
        collect(64, 0, 200);
        n_cmp++;
        if (q_coef.size() != 64) begin
            n_err++;
            $display("FAIL single_count: got %0d outputs, want 64", q_coef.size());
        end
        for (int k = 0; k < q_coef.size(); k++) begin
            e = k % 64; row = e % 8; col = e / 8; expv = 16 * row + col;
            n_cmp++;
            if (q_coef[k] !== 16'(expv) || q_idx[k] !== 3'(row) || q_last[k] !== (row == 7) || q_blast[k] !== (e == 63)) begin
                n_err++;
                $display("FAIL single_elem %0d: got coef=%0d idx=%0d last=%0b blast=%0b, want %0d %0d %0b %0b",
                         k, q_coef[k], q_idx[k], q_last[k], q_blast[k], expv, row, row == 7, e == 63);
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_drained: out_valid=%0b, want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int e, row, col, expv;
        do_reset();
        fork
            write_blocks(3, 0);
            collect(192, 0, 500);
        join
        n_cmp++;
        if (q_coef.size() != 192) begin
            n_err++;
            $display("FAIL b2b_count: got %0d outputs, want 192", q_coef.size());
        end
        n_cmp++;
        if (gaps != 0) begin
            n_err++;
            $display("FAIL b2b_gaps: got %0d bubbles, want 0", gaps);
        end
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_overflow: got %0b, want 0", overflow);
        end
        for (int k = 0; k < q_coef.size(); k++) begin
            e = k % 64; row = e % 8; col = e / 8; expv = (k / 64) * 256 + 16 * row + col;
            n_cmp++;
            if (q_coef[k] !== 16'(expv) || q_idx[k] !== 3'(row) || q_last[k] !== (row == 7) || q_blast[k] !== (e == 63)) begin
                n_err++;
                $display("FAIL b2b_elem %0d: got coef=%0d idx=%0d last=%0b blast=%0b, want %0d %0d %0b %0b",
                         k, q_coef[k], q_idx[k], q_last[k], q_blast[k], expv, row, row == 7, e == 63);
            end
        end
    endtask

    task automatic test_backpressure();
        int e, row, col, expv;
        do_reset();
        fork
            write_blocks(2, 1);
            collect(128, 1, 1000);
        join
        n_cmp++;
        if (q_coef.size() != 128) begin
            n_err++;
            $display("FAIL bp_count: got %0d outputs, want 128", q_coef.size());
        end
        n_cmp++;
        if (stall_chg != 0) begin
            n_err++;
            $display("FAIL bp_stable: got %0d output changes while stalled, want 0", stall_chg);
        end
        for (int k = 0; k < q_coef.size(); k++) begin
            e = k % 64; row = e % 8; col = e / 8; expv = (1 + k / 64) * 256 + 16 * row + col;
            n_cmp++;
            if (q_coef[k] !== 16'(expv) || q_idx[k] !== 3'(row) || q_last[k] !== (row == 7) || q_blast[k] !== (e == 63)) begin
                n_err++;
                $display("FAIL bp_elem %0d: got coef=%0d idx=%0d last=%0b blast=%0b, want %0d %0d %0b %0b",
                         k, q_coef[k], q_idx[k], q_last[k], q_blast[k], expv, row, row == 7, e == 63);
            end
        end
    endtask

    task automatic test_overflow();
        int e, row, col, expv;
        do_reset();
        write_blocks(2, 2);
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_before: got %0b, want 0 with two blocks stored", overflow);
        end
        @(negedge clk);
        in_valid = 1'b1; in_coef = 16'h7abc; in_index = 3'd0; in_last = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set: got %0b, want 1", overflow);
        end
        collect(128, 0, 300);
        n_cmp++;
        if (q_coef.size() != 128) begin
            n_err++;
            $display("FAIL ovf_count: got %0d outputs, want 128", q_coef.size());
        end
        for (int k = 0; k < q_coef.size(); k++) begin
            e = k % 64; row = e % 8; col = e / 8; expv = (2 + k / 64) * 256 + 16 * row + col;
            n_cmp++;
            if (q_coef[k] !== 16'(expv) || q_idx[k] !== 3'(row) || q_blast[k] !== (e == 63)) begin
                n_err++;
                $display("FAIL ovf_elem %0d: got coef=%0d idx=%0d blast=%0b, want %0d %0d %0b",
                         k, q_coef[k], q_idx[k], q_blast[k], expv, row, e == 63);
            end
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_after: got out_valid=%0b overflow=%0b, want 0 1", out_valid, overflow);
        end
    endtask

    task automatic test_reset_mid_drain();
        int e, row, col, expv;
        do_reset();
        write_blocks(1, 3);
        collect(20, 0, 100);
        n_cmp++;
        if (q_coef.size() != 20) begin
            n_err++;
            $display("FAIL rst_pre_count: got %0d outputs, want 20", q_coef.size());
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_immediate: out_valid=%0b, want 0", out_valid);
        end
        out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        write_blocks(1, 4);
        collect(64, 0, 200);
        n_cmp++;
        if (q_coef.size() != 64) begin
            n_err++;
            $display("FAIL rst_post_count: got %0d outputs, want 64", q_coef.size());
        end
        for (int k = 0; k < q_coef.size(); k++) begin
            e = k % 64; row = e % 8; col = e / 8; expv = 4 * 256 + 16 * row + col;
            n_cmp++;
            if (q_coef[k] !== 16'(expv) || q_idx[k] !== 3'(row) || q_blast[k] !== (e == 63)) begin
                n_err++;
                $display("FAIL rst_elem %0d: got coef=%0d idx=%0d blast=%0b, want %0d %0d %0b",
                         k, q_coef[k], q_idx[k], q_blast[k], expv, row, e == 63);
            end
        end
    endtask

    task automatic test_proto_err();
        do_reset();
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1; in_coef = 16'(c); in_index = 3'(c); in_last = (c == 5);
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        repeat (4) @(negedge clk);
`ifdef DCT_TPOSE_CHECK_EN
        n_cmp++;
        if (proto_err !== 1'b1) begin
            n_err++;
            $display("FAIL proto_set: got %0b, want 1", proto_err);
        end
        do_reset();
        n_cmp++;
        if (proto_err !== 1'b0) begin
            n_err++;
            $display("FAIL proto_clear: got %0b after reset, want 0", proto_err);
        end
`else
        n_cmp++;
        if (proto_err !== 1'b0) begin
            n_err++;
            $display("FAIL proto_tied: got %0b, want 0 without checker", proto_err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_reset_mid_drain();
        test_proto_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
